prbs7_checker: RTL and testbench

- Receive-side partner of the team's 7-bit PRBS generator. Consumes the generator's parallel 7-bit word stream, one word per enabled cycle.
- Predicted next-state rule: next(s) = {s[5:0], s[2] ^ s[6]}.
- Self-synchronises to the incoming stream, then flags and counts mismatched words.
- Sits at the far end of a loopback or link path as a built-in bit-error-rate monitor.

---
 rtl/prbs7_checker.sv | 143 ++++++++++++++
 tb/tb_prbs7_checker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/prbs7_checker.sv
// Receive-side checker for the 7-bit PRBS stream (next(s) = {s[5:0], s[2]^s[6]}).
// Self-synchronises in HUNT, then free-runs a local predictor in LOCKED and
// flags / counts every word that disagrees with it.
//
// Ports:
//   clk       - single clock, rising-edge
//   rst       - synchronous reset, active-low
//   en        - word-valid strobe; data_in only examined when en=1
//   data_in   - received 7-bit PRBS word
//   clr_err   - synchronous clear of err_cnt (wins over a same-cycle error)
//   locked    - 1 while the FSM is in LOCKED
//   err_pulse - one-cycle strobe per mismatched word while LOCKED
//   err_cnt   - saturating count of mismatched words while LOCKED
module prbs7_checker #(
    parameter int unsigned LOCK_CNT   = 8,
    parameter int unsigned UNLOCK_CNT = 4,
    parameter int unsigned ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [6:0]       data_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int unsigned MATCH_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam int unsigned MISS_W  = (UNLOCK_CNT > 1) ? $clog2(UNLOCK_CNT) : 1;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [6:0]         ref_q, ref_d;
    logic               ref_valid_q, ref_valid_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic [6:0]         pred_q, pred_d;
    logic               err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

    logic               nonzero_c;
    logic               hit_c;
    logic [6:0]         exp_c;

    function automatic logic [6:0] prbs_next(input logic [6:0] s);
        return {s[5:0], s[2] ^ s[6]};
    endfunction

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= HUNT;
            ref_q       <= 7'd0;
            ref_valid_q <= 1'b0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            pred_q      <= 7'd0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            ref_valid_q <= ref_valid_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            pred_q      <= pred_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        ref_valid_d = ref_valid_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        pred_d      = pred_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;

        // All-zero is the LFSR lock-up state and never a legal word.
        nonzero_c = |data_in;
        hit_c     = ref_valid_q && nonzero_c && (data_in == prbs_next(ref_q));
        exp_c     = prbs_next(pred_q);

        if (en) begin
            case (state_q)
                HUNT: begin
                    ref_d       = data_in;
                    ref_valid_d = nonzero_c;
                    if (hit_c && (match_cnt_q == MATCH_W'(LOCK_CNT - 1))) begin
                        state_d     = LOCKED;
                        pred_d      = data_in;
                        miss_cnt_d  = '0;
                        match_cnt_d = '0;
                    end else if (hit_c) begin
                        match_cnt_d = match_cnt_q + MATCH_W'(1);
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    // Predictor free-runs so one corrupted word costs one error.
                    pred_d = exp_c;
                    if (!nonzero_c || (data_in != exp_c)) begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != {ERR_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                        if (miss_cnt_q == MISS_W'(UNLOCK_CNT - 1)) begin
                            state_d     = HUNT;
                            ref_d       = data_in;
                            ref_valid_d = nonzero_c;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + MISS_W'(1);
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (clr_err) begin
            err_cnt_d = '0;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// Directed bench for prbs7_checker: a default instance (ERR_W=16) and a
// narrow instance (ERR_W=4) share one stimulus stream.
module tb_prbs7_checker;

    logic        clk;
    logic        rst;
    logic        en;
    logic [6:0]  data_in;
    logic        clr_err;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_cnt;
    logic        locked4;
    logic        err_pulse4;
    logic [3:0]  err_cnt4;

    int checks = 0;
    int errors = 0;
    logic [6:0] gen;

    prbs7_checker dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .data_in   (data_in),
        .clr_err   (clr_err),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    prbs7_checker #(.LOCK_CNT(8), .UNLOCK_CNT(4), .ERR_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .data_in   (data_in),
        .clr_err   (clr_err),
        .locked    (locked4),
        .err_pulse (err_pulse4),
        .err_cnt   (err_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] nxt(input logic [6:0] s);
        return {s[5:0], s[2] ^ s[6]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample #1 after the rising edge.
    task automatic tick(input logic e, input logic [6:0] d, input logic c);
        en      = e;
        data_in = d;
        clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_clean(input logic c);
        tick(1'b1, gen, c);
        gen = nxt(gen);
    endtask

    // Replace the next generator word with a corrupted one.
    task automatic send_bad(input logic [6:0] d, input logic c);
        tick(1'b1, d, c);
        gen = nxt(gen);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; data_in = 7'd0; clr_err = 1'b0;
        gen = 7'h01;

        // Reset state
        tick(1'b1, 7'h01, 1'b1);
        tick(1'b1, 7'h02, 1'b0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_pulse", 32'(err_pulse), 32'd0);
        chk("rst_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b1;

        // Lock acquisition: locked stays low through word 8, rises on word 9
        for (int i = 1; i <= 8; i++) begin
            send_clean(1'b0);
            chk("acq_unlocked", 32'(locked), 32'd0);
        end
        send_clean(1'b0);
        chk("acq_locked", 32'(locked), 32'd1);
        chk("acq_cnt", 32'(err_cnt), 32'd0);

        // Single error costs exactly one count
        for (int i = 0; i < 3; i++) send_clean(1'b0);
        send_bad(gen ^ 7'h10, 1'b0);
        chk("single_pulse", 32'(err_pulse), 32'd1);
        chk("single_cnt", 32'(err_cnt), 32'd1);
        chk("single_locked", 32'(locked), 32'd1);
        for (int i = 0; i < 10; i++) begin
            send_clean(1'b0);
            chk("single_no_follow", 32'(err_pulse), 32'd0);
        end
        chk("single_cnt_after", 32'(err_cnt), 32'd1);
        chk("single_locked_after", 32'(locked), 32'd1);

        // Loss of lock after 4 consecutive 0x55 words (counter cleared first)
        send_clean(1'b1);
        chk("clr_cnt", 32'(err_cnt), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            send_bad(7'h55, 1'b0);
            chk("lol_pulse", 32'(err_pulse), 32'd1);
            chk("lol_cnt", 32'(err_cnt), 32'(i));
            chk("lol_locked", 32'(locked), (i < 4) ? 32'd1 : 32'd0);
        end
        for (int i = 1; i <= 8; i++) begin
            send_clean(1'b0);
            chk("relock_unlocked", 32'(locked), 32'd0);
            chk("relock_no_pulse", 32'(err_pulse), 32'd0);
        end
        send_clean(1'b0);
        chk("relock_locked", 32'(locked), 32'd1);
        chk("relock_cnt", 32'(err_cnt), 32'd4);

        // en gaps: predictor holds while en=0
        send_clean(1'b0);
        tick(1'b0, 7'h00, 1'b0);
        chk("gap_pulse0", 32'(err_pulse), 32'd0);
        tick(1'b0, 7'h55, 1'b0);
        chk("gap_pulse1", 32'(err_pulse), 32'd0);
        send_clean(1'b0);
        chk("gap_resume_pulse", 32'(err_pulse), 32'd0);
        chk("gap_cnt", 32'(err_cnt), 32'd4);
        chk("gap_locked", 32'(locked), 32'd1);

        // clr_err wins over a same-cycle error, pulse still fires
        send_bad(gen ^ 7'h01, 1'b1);
        chk("clr_err_pulse", 32'(err_pulse), 32'd1);
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);
        tick(1'b0, 7'h00, 1'b0);
        chk("clr_pulse_drop_en0", 32'(err_pulse), 32'd0);
        send_clean(1'b0);
        chk("clr_after_pulse", 32'(err_pulse), 32'd0);

        // A single all-zero word while locked counts one error
        send_bad(7'h00, 1'b0);
        chk("zero_pulse", 32'(err_pulse), 32'd1);
        chk("zero_cnt", 32'(err_cnt), 32'd1);
        chk("zero_locked", 32'(locked), 32'd1);
        send_clean(1'b0);

        // Saturation: 20 isolated errors
        for (int i = 0; i < 20; i++) begin
            send_bad(gen ^ 7'h40, 1'b0);
            send_clean(1'b0);
        end
        chk("sat_cnt4", 32'(err_cnt4), 32'd15);
        chk("sat_cnt16", 32'(err_cnt), 32'd21);
        chk("sat_locked", 32'(locked4), 32'd1);

        // Reset mid-stream
        rst = 1'b0;
        send_clean(1'b0);
        rst = 1'b1;
        chk("midrst_locked", 32'(locked), 32'd0);
        chk("midrst_cnt", 32'(err_cnt), 32'd0);
        chk("midrst_cnt4", 32'(err_cnt4), 32'd0);
        chk("midrst_pulse", 32'(err_pulse), 32'd0);

        // All-zero stream from reset never locks
        rst = 1'b0;
        tick(1'b1, 7'h00, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 7'h00, 1'b0);
            chk("allzero_unlocked", 32'(locked), 32'd0);
        end
        chk("allzero_cnt", 32'(err_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
